bldc_drive_sequencer: RTL and testbench

//   Closed-loop drive sequencer for the BLDC motor / motor emulator. Accepts speed commands
//   (duty, direction), ramps the applied duty frame by frame and generates the

---
 rtl/bldc_drive_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_bldc_drive_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_drive_sequencer.sv
// rtl/bldc_drive_sequencer.sv - BLDC drive sequencer: duty ramp, reversal dead time, quadrature position
//
// Purpose: accepts (duty, direction) commands, ramps the applied duty once per
//   PWM frame, drives a never-overlapping motor_positive/motor_negative PWM
//   pair, and forces DEAD_FRAMES of both-poles-low before a direction reversal.
//   Decodes encoder_a/encoder_b into a wrapping signed position count.
// Optional feature: define BLDC_STALL_DETECT_EN to enable stall detection
//   (FAULT state, fault output, STALL_FRAMES parameter).
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_duty, cmd_dir           target duty (clocks, clamped to PWM_PERIOD), direction (1 = positive)
//   encoder_a, encoder_b        asynchronous quadrature inputs
//   motor_positive/negative     registered PWM outputs
//   position                    quadrature count, wraps mod 2^DATA_WIDTH
//   busy                        ramping or in dead interval
//   fault                       stall fault (0 when feature is disabled)
module bldc_drive_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int PWM_PERIOD   = 100,
  parameter int RAMP_STEP    = 10,
  parameter int DEAD_FRAMES  = 2
`ifdef BLDC_STALL_DETECT_EN
  ,
  parameter int STALL_FRAMES = 50
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_duty,
  input  logic                  cmd_dir,
  input  logic                  encoder_a,
  input  logic                  encoder_b,
  output logic                  motor_positive,
  output logic                  motor_negative,
  output logic [DATA_WIDTH-1:0] position,
  output logic                  busy,
  output logic                  fault
);

  localparam logic [DATA_WIDTH-1:0] PERIOD    = DATA_WIDTH'(PWM_PERIOD);
  localparam logic [DATA_WIDTH-1:0] STEP      = DATA_WIDTH'(RAMP_STEP);
  localparam logic [DATA_WIDTH-1:0] DEAD_LAST = DATA_WIDTH'(DEAD_FRAMES - 1);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DEAD, ST_FAULT} state_t;

  state_t                state, nxt_state;
  logic [DATA_WIDTH-1:0] frame_ctr;
  logic                  frame_start;
  logic [DATA_WIDTH-1:0] cur_duty, nxt_cur_duty;
  logic                  cur_dir, nxt_cur_dir;
  logic [DATA_WIDTH-1:0] dead_cnt, nxt_dead_cnt;
  logic [DATA_WIDTH-1:0] target_duty;
  logic                  target_dir;
  logic                  cmd_accept;
  logic                  pwm_on;

  logic [1:0]            enc_meta, enc_sync, enc_prev;
  logic                  step_fwd, step_rev, enc_step;
  logic                  stall_hit;

  assign frame_start = (frame_ctr == '0);
  assign cmd_ready   = (state != ST_FAULT);
  assign cmd_accept  = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_ctr <= '0;
    end else if (frame_ctr == PERIOD - 1'b1) begin
      frame_ctr <= '0;
    end else begin
      frame_ctr <= frame_ctr + 1'b1;
    end
  end

  // Target is latched immediately; the FSM only samples it at frame_start,
  // so an accept on the frame_start edge is seen one frame later.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_duty <= '0;
      target_dir  <= 1'b1;
    end else if (cmd_accept) begin
      target_duty <= (cmd_duty > PERIOD) ? PERIOD : cmd_duty;
      target_dir  <= cmd_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_STOP;
      cur_duty <= '0;
      cur_dir  <= 1'b1;
      dead_cnt <= '0;
    end else begin
      state    <= nxt_state;
      cur_duty <= nxt_cur_duty;
      cur_dir  <= nxt_cur_dir;
      dead_cnt <= nxt_dead_cnt;
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_cur_duty = cur_duty;
    nxt_cur_dir  = cur_dir;
    nxt_dead_cnt = dead_cnt;
    if (frame_start) begin
      case (state)
        ST_STOP: begin
          nxt_cur_duty = '0;
          if (target_duty != '0) begin
            nxt_state    = ST_RUN;
            nxt_cur_dir  = target_dir;
            nxt_cur_duty = (target_duty > STEP) ? STEP : target_duty;
          end
        end
        ST_RUN: begin
          if (target_dir == cur_dir) begin
            if (cur_duty == '0 && target_duty == '0) begin
              nxt_state = ST_STOP;
            end else if (cur_duty < target_duty) begin
              nxt_cur_duty = (target_duty - cur_duty > STEP) ? cur_duty + STEP : target_duty;
            end else if (cur_duty > target_duty) begin
              nxt_cur_duty = (cur_duty - target_duty > STEP) ? cur_duty - STEP : target_duty;
            end
          end else if (cur_duty == '0) begin
            nxt_state    = ST_DEAD;
            nxt_dead_cnt = '0;
          end else begin
            nxt_cur_duty = (cur_duty > STEP) ? cur_duty - STEP : '0;
          end
        end
        ST_DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            nxt_cur_dir  = target_dir;
            nxt_cur_duty = '0;
            nxt_state    = (target_duty != '0) ? ST_RUN : ST_STOP;
          end else begin
            nxt_dead_cnt = dead_cnt + 1'b1;
          end
        end
        default: begin
          nxt_cur_duty = '0;
        end
      endcase
      if (stall_hit) begin
        nxt_state    = ST_FAULT;
        nxt_cur_duty = '0;
      end
    end
  end

  // The compare uses the next-state values so that a duty change lands on
  // the first registered output of a frame rather than one clock into it.
  assign pwm_on = (nxt_state == ST_RUN) && (frame_ctr < nxt_cur_duty);

  always_ff @(posedge clk) begin
    if (reset) begin
      motor_positive <= 1'b0;
      motor_negative <= 1'b0;
      busy           <= 1'b0;
    end else begin
      motor_positive <= pwm_on && nxt_cur_dir;
      motor_negative <= pwm_on && !nxt_cur_dir;
      busy           <= (state == ST_DEAD) ||
                        ((state != ST_FAULT) && (cur_duty != target_duty));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_meta <= 2'b00;
      enc_sync <= 2'b00;
      enc_prev <= 2'b00;
    end else begin
      enc_meta <= {encoder_a, encoder_b};
      enc_sync <= enc_meta;
      enc_prev <= enc_sync;
    end
  end

  // Gray sequence {a,b}: 00 -> 01 -> 11 -> 10 -> 00 is forward.
  // Double-bit changes are illegal and ignored.
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    case ({enc_prev, enc_sync})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_rev = 1'b1;
      default: ;
    endcase
  end
  assign enc_step = step_fwd || step_rev;

  always_ff @(posedge clk) begin
    if (reset) begin
      position <= '0;
    end else if (step_fwd) begin
      position <= position + 1'b1;
    end else if (step_rev) begin
      position <= position - 1'b1;
    end
  end

`ifdef BLDC_STALL_DETECT_EN
  logic [DATA_WIDTH-1:0] stall_cnt;

  assign stall_hit = (state == ST_RUN) && (cur_duty != '0) && !enc_step &&
                     (stall_cnt == DATA_WIDTH'(STALL_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (enc_step || !(state == ST_RUN && cur_duty != '0)) begin
      stall_cnt <= '0;
    end else if (frame_start) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign fault = (state == ST_FAULT);
`else
  assign stall_hit = 1'b0;
  assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// tb/tb_bldc_drive_sequencer.sv - directed self-checking bench for bldc_drive_sequencer
module tb_bldc_drive_sequencer;

  localparam int PERIOD = 100;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_duty;
  logic        cmd_dir;
  logic        encoder_a;
  logic        encoder_b;
  logic        motor_positive;
  logic        motor_negative;
  logic [15:0] position;
  logic        busy;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int tb_ctr = 0;

  bldc_drive_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_duty       (cmd_duty),
    .cmd_dir        (cmd_dir),
    .encoder_a      (encoder_a),
    .encoder_b      (encoder_b),
    .motor_positive (motor_positive),
    .motor_negative (motor_negative),
    .position       (position),
    .busy           (busy),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame counter: frame window n spans the outputs registered
  // while tb_ctr was 0..PERIOD-1.
  always @(posedge clk) begin
    if (reset) tb_ctr <= 0;
    else       tb_ctr <= (tb_ctr == PERIOD - 1) ? 0 : tb_ctr + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic measure_frame(output int pc, output int nc, output int bc, output int fc);
    int guard;
    pc = 0; nc = 0; bc = 0; fc = 0; guard = 0;
    @(negedge clk);
    while (tb_ctr != 1 && guard < 2 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (tb_ctr != 1) begin
      errors++;
      $display("FAIL frame_align got %0d expected 1", tb_ctr);
    end
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      pc += int'(motor_positive);
      nc += int'(motor_negative);
      bc += int'(motor_positive && motor_negative);
      fc += int'(fault);
    end
  endtask

  task automatic send_cmd(input int duty, input logic dir);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((tb_ctr < 10 || tb_ctr > 50) && guard < 2 * PERIOD);
    cmd_valid = 1'b1;
    cmd_duty  = 16'(duty);
    cmd_dir   = dir;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({motor_positive, motor_negative, busy, fault, cmd_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 00001",
               {motor_positive, motor_negative, busy, fault, cmd_ready});
    end
    checks++;
    if (position !== 16'h0000) begin
      errors++;
      $display("FAIL reset_position got %h expected 0000", position);
    end
    reset = 1'b0;
  endtask

  task automatic test_ramp;
    int pc, nc, bc, fc;
    int exp_p[4] = '{10, 20, 30, 30};
    int exp_b[4] = '{1, 1, 0, 0};
    send_cmd(30, 1'b1);
    for (int f = 0; f < 4; f++) begin
      measure_frame(pc, nc, bc, fc);
      checks++;
      if (pc != exp_p[f] || nc != 0 || bc != 0) begin
        errors++;
        $display("FAIL ramp_frame%0d got pos %0d neg %0d both %0d expected pos %0d neg 0 both 0",
                 f, pc, nc, bc, exp_p[f]);
      end
      checks++;
      if (busy !== exp_b[f][0]) begin
        errors++;
        $display("FAIL ramp_busy%0d got %b expected %0d", f, busy, exp_b[f]);
      end
    end
  endtask

  task automatic test_reversal;
    int pc, nc, bc, fc;
    int exp_p[8] = '{20, 10, 0, 0, 0, 0, 0, 0};
    int exp_n[8] = '{0, 0, 0, 0, 0, 0, 10, 20};
    int exp_b[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    send_cmd(20, 1'b0);
    for (int f = 0; f < 8; f++) begin
      measure_frame(pc, nc, bc, fc);
      checks++;
      if (pc != exp_p[f] || nc != exp_n[f] || bc != 0) begin
        errors++;
        $display("FAIL rev_frame%0d got pos %0d neg %0d both %0d expected pos %0d neg %0d both 0",
                 f, pc, nc, bc, exp_p[f], exp_n[f]);
      end
      checks++;
      if (busy !== exp_b[f][0]) begin
        errors++;
        $display("FAIL rev_busy%0d got %b expected %0d", f, busy, exp_b[f]);
      end
    end
  endtask

  task automatic test_encoder;
    logic [1:0] fwd [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] rev [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [15:0] exp;
    // Latency on the first step: unchanged after 2 clocks, updated after 3.
    {encoder_a, encoder_b} = fwd[0];
    repeat (2) @(negedge clk);
    checks++;
    if (position !== 16'd0) begin
      errors++;
      $display("FAIL enc_latency2 got %0d expected 0", position);
    end
    @(negedge clk);
    checks++;
    if (position !== 16'd1) begin
      errors++;
      $display("FAIL enc_latency3 got %0d expected 1", position);
    end
    for (int i = 1; i < 16; i++) begin
      {encoder_a, encoder_b} = fwd[i % 4];
      repeat (3) @(negedge clk);
      exp = 16'(i + 1);
      checks++;
      if (position !== exp) begin
        errors++;
        $display("FAIL enc_fwd%0d got %0d expected %0d", i, position, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      {encoder_a, encoder_b} = rev[i % 4];
      repeat (3) @(negedge clk);
      exp = 16'(15 - i);
      checks++;
      if (position !== exp) begin
        errors++;
        $display("FAIL enc_rev%0d got %0d expected %0d", i, position, exp);
      end
    end
    {encoder_a, encoder_b} = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if (position !== 16'd8) begin
      errors++;
      $display("FAIL enc_jump got %0d expected 8", position);
    end
    {encoder_a, encoder_b} = 2'b00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      {encoder_a, encoder_b} = rev[i % 4];
      repeat (3) @(negedge clk);
    end
    checks++;
    if (position !== 16'd0) begin
      errors++;
      $display("FAIL enc_zero got %0d expected 0", position);
    end
    {encoder_a, encoder_b} = rev[0];
    repeat (3) @(negedge clk);
    checks++;
    if (position !== 16'hFFFF) begin
      errors++;
      $display("FAIL enc_wrap got %h expected ffff", position);
    end
  endtask

  task automatic test_reset_mid_run;
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (tb_ctr != 5 && guard < 2 * PERIOD);
    checks++;
    if (motor_negative !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre got %b expected 1", motor_negative);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({motor_positive, motor_negative, busy, fault, cmd_ready} !== 5'b00001 ||
        position !== 16'h0000) begin
      errors++;
      $display("FAIL midrun_reset got %b pos %h expected 00001 pos 0000",
               {motor_positive, motor_negative, busy, fault, cmd_ready}, position);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_clamp;
    int pc, nc, bc, fc;
    int exp;
    send_cmd(150, 1'b1);
    for (int f = 0; f < 11; f++) begin
      measure_frame(pc, nc, bc, fc);
      exp = (f < 10) ? 10 * (f + 1) : 100;
      checks++;
      if (pc != exp || nc != 0) begin
        errors++;
        $display("FAIL clamp_frame%0d got pos %0d neg %0d expected pos %0d neg 0", f, pc, nc, exp);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_busy got %b expected 0", busy);
    end
  endtask

  task automatic test_stall;
    int pc, nc, bc, fc;
    int exp_p[5] = '{90, 80, 70, 60, 50};
    send_cmd(50, 1'b1);
    for (int f = 0; f < 5; f++) begin
      measure_frame(pc, nc, bc, fc);
      checks++;
      if (pc != exp_p[f]) begin
        errors++;
        $display("FAIL stall_ramp%0d got %0d expected %0d", f, pc, exp_p[f]);
      end
    end
`ifdef BLDC_STALL_DETECT_EN
    begin
      int n;
      n = 0;
      while (fault !== 1'b1 && n < 80) begin
        measure_frame(pc, nc, bc, fc);
        n++;
      end
      checks++;
      if (fault !== 1'b1) begin
        errors++;
        $display("FAIL stall_fault got %b expected 1", fault);
      end
      measure_frame(pc, nc, bc, fc);
      checks++;
      if (pc != 0 || nc != 0 || cmd_ready !== 1'b0 || busy !== 1'b0 || fc != PERIOD) begin
        errors++;
        $display("FAIL stall_hold got pos %0d neg %0d ready %b busy %b fault %0d expected 0 0 0 0 %0d",
                 pc, nc, cmd_ready, busy, fc, PERIOD);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (fault !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL stall_clear got fault %b ready %b expected 0 1", fault, cmd_ready);
      end
    end
`else
    begin
      int fsum;
      fsum = 0;
      for (int f = 0; f < 53; f++) begin
        measure_frame(pc, nc, bc, fc);
        fsum += fc;
      end
      checks++;
      if (fsum != 0) begin
        errors++;
        $display("FAIL nostall_fault got %0d expected 0", fsum);
      end
      checks++;
      if (pc != 50 || nc != 0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL nostall_pwm got pos %0d neg %0d ready %b expected 50 0 1", pc, nc, cmd_ready);
      end
    end
`endif
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_duty  = 16'd0;
    cmd_dir   = 1'b1;
    encoder_a = 1'b0;
    encoder_b = 1'b0;
    test_reset;
    test_ramp;
    test_reversal;
    test_encoder;
    test_reset_mid_run;
    test_clamp;
    test_stall;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
